// File: rtl/parity_mem_pkg.sv
// Shared types and default geometry for the parity-protected memory.
package parity_mem_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  // INIT scrubs every word to zero with valid parity; RUN is normal access.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/parity_mem_parity_gen.sv
// Parity of a data word; ODD_PARITY selects the sense of the generated bit.
module parity_gen #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

  assign parity = (^data) ^ (ODD_PARITY != 0);

endmodule

// File: rtl/parity_mem.sv
// Single-port-write / single-port-read memory storing one parity bit per word,
// with power-on scrub, error injection on write and a saturating error counter.
module parity_mem
  import parity_mem_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_inj,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_parity,
  output logic              rd_valid,
  output logic              rd_err,
  output logic [7:0]        err_cnt,
  input  logic              err_clr,
  output logic              busy
);

  localparam int DEPTH = 2**ADDR_W;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   init_ptr;
  logic [DATA_W:0]     mem [DEPTH];

  logic                in_run;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                wpar;
  logic                wpar_final;
  logic [DATA_W:0]     rd_word;
  logic                rd_chk;
  logic                rd_acc;

  assign in_run = (state == RUN);
  assign busy   = (state == INIT);

  // During INIT the write port is taken over by the scrubber: zero data, true parity.
  assign mem_we     = in_run ? wr_en   : 1'b1;
  assign mem_waddr  = in_run ? wr_addr : init_ptr;
  assign mem_wdata  = in_run ? wr_data : '0;
  assign wpar_final = wpar ^ (in_run & wr_inj);

  assign rd_word = mem[rd_addr];
  assign rd_acc  = in_run & rd_en;

  parity_gen #(.DATA_W(DATA_W), .ODD_PARITY(ODD_PARITY)) u_wr_par (
    .data   (mem_wdata),
    .parity (wpar)
  );

  parity_gen #(.DATA_W(DATA_W), .ODD_PARITY(ODD_PARITY)) u_rd_chk (
    .data   (rd_word[DATA_W-1:0]),
    .parity (rd_chk)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nxt;
  end

  // Next-state: leave INIT once the last address has been scrubbed.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT: if (init_ptr == ADDR_W'(DEPTH - 1)) state_nxt = RUN;
      RUN:  state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // Scrub pointer advances one word per INIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              init_ptr <= '0;
    else if (state == INIT)  init_ptr <= init_ptr + 1'b1;
  end

  // Storage array; not reset, contents defined by the INIT scrub.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= {wpar_final, mem_wdata};
  end

  // Registered read port; non-blocking update of mem gives read-first on collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_parity <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data   <= rd_word[DATA_W-1:0];
        rd_parity <= rd_word[DATA_W];
        rd_err    <= (rd_chk != rd_word[DATA_W]);
      end
    end
  end

  // Saturating error counter; clear has priority over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     err_cnt <= '0;
    else if (in_run && err_clr)                     err_cnt <= '0;
    else if (rd_valid && rd_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end

endmodule

// File: tb/tb_parity_mem.sv
// Scoreboard bench for parity_mem: an even- and an odd-parity instance share stimulus.
module tb_parity_mem;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0, wr_inj = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [2:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] wr_data = '0;

  logic [7:0] rd_data, rd_data_o, err_cnt, err_cnt_o;
  logic       rd_parity, rd_valid, rd_err, busy;
  logic       rd_parity_o, rd_valid_o, rd_err_o, busy_o;

  always #5 clk = ~clk;

  parity_mem #(.DATA_W(8), .ADDR_W(3), .ODD_PARITY(0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_inj(wr_inj), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_parity(rd_parity), .rd_valid(rd_valid), .rd_err(rd_err), .err_cnt(err_cnt),
    .err_clr(err_clr), .busy(busy)
  );

  parity_mem #(.DATA_W(8), .ADDR_W(3), .ODD_PARITY(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_inj(wr_inj), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o),
    .rd_parity(rd_parity_o), .rd_valid(rd_valid_o), .rd_err(rd_err_o), .err_cnt(err_cnt_o),
    .err_clr(err_clr), .busy(busy_o)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       e;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mem_m [8];
  logic       par_m [8];   // parity bit as stored by the even instance
  int         cnt_m;
  logic       vld_m, err_m;
  logic [7:0] last_d;
  logic       last_p, last_po;
  int         errors = 0;
  int         checks = 0;

  // One RUN cycle: drive, update model, clock, then compare against the scoreboard.
  task automatic do_op(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic inj, input logic re, input logic [2:0] ra,
                       input logic clr);
    exp_t e, got;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_inj = inj;
    rd_en = re; rd_addr = ra; err_clr = clr;
    if (clr) cnt_m = 0;
    else if (vld_m && err_m && cnt_m < 255) cnt_m = cnt_m + 1;
    if (re) begin
      e.d = mem_m[ra]; e.p = par_m[ra]; e.e = (^mem_m[ra]) != par_m[ra];
      q.push_back(e);
    end
    if (we) begin
      mem_m[wa] = wd; par_m[wa] = (^wd) ^ inj;
    end
    @(posedge clk); #1;
    got = '0;
    if (re) begin
      got = q.pop_front();
      last_d = got.d; last_p = got.p; last_po = ~got.p;
    end
    vld_m = re; err_m = re ? got.e : 1'b0;
    checks++;
    if (rd_valid !== re || rd_valid_o !== re) begin
      errors++; $display("FAIL rd_valid: got %b/%b want %b", rd_valid, rd_valid_o, re);
    end
    checks++;
    if (rd_data !== last_d || rd_data_o !== last_d) begin
      errors++; $display("FAIL rd_data: got %h/%h want %h", rd_data, rd_data_o, last_d);
    end
    checks++;
    if (rd_parity !== last_p || rd_parity_o !== last_po) begin
      errors++; $display("FAIL rd_parity: got %b/%b want %b/%b", rd_parity, rd_parity_o, last_p, last_po);
    end
    if (re) begin
      checks++;
      if (rd_err !== got.e || rd_err_o !== got.e) begin
        errors++; $display("FAIL rd_err: got %b/%b want %b", rd_err, rd_err_o, got.e);
      end
    end
    checks++;
    if (err_cnt !== 8'(cnt_m) || err_cnt_o !== 8'(cnt_m)) begin
      errors++; $display("FAIL err_cnt: got %0d/%0d want %0d", err_cnt, err_cnt_o, cnt_m);
    end
  endtask

  task automatic idle();
    do_op(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  // Assert reset now and verify every output drops to its reset value at once.
  task automatic assert_reset(input string tag);
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_parity !== 1'b0 || rd_data !== 8'h00 ||
        err_cnt !== 8'h00 || busy !== 1'b1 || rd_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_%s: vld=%b err=%b par=%b data=%h cnt=%0d busy=%b want 0 0 0 00 0 1",
               tag, rd_valid, rd_err, rd_parity, rd_data, err_cnt, busy);
    end
    q.delete();
    cnt_m = 0; vld_m = 0; err_m = 0; last_d = 0; last_p = 0; last_po = 0;
    wr_en = 0; rd_en = 0; err_clr = 0; wr_inj = 0;
    @(negedge clk); @(negedge clk);
  endtask

  // Release reset and walk n INIT cycles with all strobes held high (they must be ignored).
  task automatic run_init(input int n);
    rst_n = 1'b1;
    wr_en = 1; wr_addr = 3'd7; wr_data = 8'hFF; wr_inj = 1; rd_en = 1; rd_addr = 3'd3; err_clr = 1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rd_valid !== 1'b0 || rd_valid_o !== 1'b0) begin
        errors++; $display("FAIL init_rd_valid: cycle %0d got %b want 0", i, rd_valid);
      end
      checks++;
      if (busy !== (i < 7) || busy_o !== (i < 7)) begin
        errors++; $display("FAIL init_busy: cycle %0d got %b want %b", i, busy, (i < 7));
      end
    end
    wr_en = 0; wr_inj = 0; rd_en = 0; err_clr = 0;
    if (n >= 8) begin
      for (int a = 0; a < 8; a++) begin
        mem_m[a] = 8'h00; par_m[a] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    assert_reset("power_on");
    run_init(8);
    do_op(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd5, 1'b0);
    checks++;
    if (rd_data !== 8'h00 || rd_parity !== 1'b0 || rd_err !== 1'b0) begin
      errors++; $display("FAIL read_addr5: got %h/%b/%b want 00/0/0", rd_data, rd_parity, rd_err);
    end
    idle();
  endtask

  task automatic test_parity();
    do_op(1'b1, 3'd0, 8'h1F, 1'b0, 1'b0, 3'd0, 1'b0);
    do_op(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0);
    checks++;
    if (rd_data !== 8'h1F || rd_parity !== 1'b1 || rd_parity_o !== 1'b0 || rd_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_1f: got %h even=%b odd=%b err=%b want 1f 1 0 0", rd_data, rd_parity, rd_parity_o, rd_err);
    end
    idle();
    idle();
  endtask

  task automatic test_inject();
    do_op(1'b1, 3'd1, 8'h31, 1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) do_op(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd1, 1'b0);
    idle();
    checks++;
    if (err_cnt !== 8'd3) begin
      errors++; $display("FAIL inject_cnt: got %0d want 3", err_cnt);
    end
    do_op(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1);
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++; $display("FAIL inject_clr: got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_read_first();
    do_op(1'b1, 3'd2, 8'h53, 1'b0, 1'b0, 3'd0, 1'b0);
    do_op(1'b1, 3'd2, 8'hAA, 1'b0, 1'b1, 3'd2, 1'b0);
    checks++;
    if (rd_data !== 8'h53) begin
      errors++; $display("FAIL read_first_old: got %h want 53", rd_data);
    end
    do_op(1'b1, 3'd3, 8'h11, 1'b0, 1'b1, 3'd2, 1'b0);
    checks++;
    if (rd_data !== 8'hAA) begin
      errors++; $display("FAIL read_first_new: got %h want aa", rd_data);
    end
    do_op(1'b1, 3'd4, 8'h7E, 1'b0, 1'b1, 3'd3, 1'b0);
    idle();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) do_op(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd1, 1'b0);
    idle();
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++; $display("FAIL saturate: got %0d want 255", err_cnt);
    end
    do_op(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd1, 1'b0);
    do_op(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1);
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++; $display("FAIL clr_priority: got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++)
      do_op(1'($urandom), 3'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0),
            1'($urandom), 3'($urandom), ($urandom_range(0, 15) == 0));
    idle();
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    assert_reset("run");
    run_init(4);
    assert_reset("mid_init");
    run_init(8);
    do_op(1'b1, 3'd6, 8'hC3, 1'b0, 1'b0, 3'd0, 1'b0);
    do_op(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd6, 1'b0);
    assert_reset("mid_read");
    run_init(8);
    do_op(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd6, 1'b0);
    checks++;
    if (rd_data !== 8'h00) begin
      errors++; $display("FAIL rescrub: got %h want 00", rd_data);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_parity();
    test_inject();
    test_read_first();
    test_saturate();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/parity_mem.md
PARITY_MEM -- requirements
Module: parity_mem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data word width.
REQ-002 The block SHALL have parameter ADDR_W, default 3, address width; depth = 2**ADDR_W.
REQ-003 The block SHALL have parameter ODD_PARITY, default 0, where 0 selects even parity (data plus parity has an even count of ones) and 1 selects odd parity.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports ordered as follows:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_inj  in  1  with wr_en, store inverted parity (error injection)
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  registered read data
- rd_parity  out  1  stored parity bit of the word read
- rd_valid  out  1  one-cycle pulse; rd_data, rd_parity and rd_err are valid
- rd_err  out  1  parity mismatch on the word read; qualified by rd_valid
- err_cnt  out  8  saturating count of read parity errors
- err_clr  in  1  synchronous clear of err_cnt
- busy  out  1  high while initialisation runs

Function
REQ-005 Storage SHALL be 2**ADDR_W words of DATA_W+1 bits: data plus one parity bit.
REQ-006 The stored parity SHALL be the XOR-reduction of wr_data, inverted when ODD_PARITY=1, and inverted again when wr_inj=1.
REQ-007 The FSM SHALL have two states. INIT writes all-zero data with correct parity to address init_ptr, one word per cycle, from 0 to 2**ADDR_W-1. RUN is normal operation.
REQ-008 INIT SHALL last exactly 2**ADDR_W cycles after reset release, then move to RUN; busy SHALL be 1 in INIT and 0 in RUN.
REQ-009 In INIT, wr_en, rd_en and err_clr SHALL be ignored; rd_valid SHALL stay 0.
REQ-010 In RUN, a write SHALL take effect at the clock edge on which wr_en=1 is sampled.
REQ-011 In RUN, a read SHALL have one-cycle latency: rd_en sampled at edge N gives rd_valid=1 and data in the cycle after edge N. rd_valid SHALL be 0 in any cycle not following an accepted read.
REQ-012 rd_data and rd_parity SHALL hold their last values while rd_valid=0.
REQ-013 rd_err SHALL be 1 when the recomputed parity of the stored data (per ODD_PARITY) differs from the stored parity bit, and 0 otherwise.
REQ-014 A read and a write to the same address in the same cycle SHALL be read-first: the read returns the old word. Different addresses SHALL proceed independently.
REQ-015 err_cnt SHALL increment by 1 on each cycle where rd_valid and rd_err are both 1, and SHALL saturate at 255 with no wrap.
REQ-016 When err_clr=1 and an increment occur in the same cycle, err_clr SHALL win and err_cnt SHALL become 0.

Reset
REQ-017 rst_n=0 SHALL immediately force: state=INIT, init_ptr=0, busy=1, rd_valid=0, rd_err=0, rd_parity=0, rd_data=0, err_cnt=0.
REQ-018 Reset asserted mid-INIT or mid-RUN SHALL abort the current operation; after release, INIT SHALL restart from address 0 and rerun its full length.
REQ-019 Memory contents SHALL NOT be reset directly; they become defined only through INIT.

Structure
REQ-020 Package parity_mem_pkg SHALL hold the FSM state enum (INIT, RUN) and the default values of DATA_W and ADDR_W.
REQ-021 Parity computation SHALL live in the sub-module parity_gen (parameters DATA_W and ODD_PARITY), instantiated once for the write path and once for the read check.

Verification
REQ-022 Release reset with defaults -> busy=1 for exactly 8 cycles, then 0; reading address 5 returns rd_data=0x00, rd_parity=0, rd_err=0.
REQ-023 Write 0x1F to address 0, then read it -> rd_data=0x1F, rd_parity=1, rd_err=0 (even); repeat with ODD_PARITY=1 -> rd_parity=0.
REQ-024 Write 0x31 to address 1 with wr_inj=1, then read it 3 times -> rd_err=1 on each rd_valid and err_cnt=3; assert err_clr -> err_cnt=0.
REQ-025 In the same cycle, write 0xAA and read address 2, which holds 0x53 -> rd_data=0x53; the next read -> 0xAA.
REQ-026 Make 260 consecutive erroneous reads -> err_cnt stops at 255; err_clr on the same cycle as an error -> err_cnt=0.
REQ-027 Pull rst_n low when init_ptr=4 and also during a RUN read -> all outputs take their reset values at once, rd_valid stays 0, and busy stays high for 8 full cycles after release.
